// File: rtl/i2c_dyna_cmd_arb_if.sv
// Client-side and FIFO-side signal bundle for the dynamic-mode command arbiter.
// The arbiter connects through the slave modport; the clients and FIFOs through the master modport.
interface i2c_dyna_cmd_arb_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
);
    logic                 cr_en;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [7*NREQ-1:0]    req_addr;
    logic [NREQ-1:0]      req_rw;
    logic [8*NREQ-1:0]    req_len;
    logic [NREQ-1:0]      wr_valid;
    logic [NREQ-1:0]      wr_ready;
    logic [8*NREQ-1:0]    wr_data;
    logic [NREQ-1:0]      done;
    logic [NREQ-1:0]      err;
    logic                 busy;
    logic [IDW-1:0]       grant_id;
    logic                 tx_fifo_full;
    logic                 tx_fifo_wr;
    logic [9:0]           tx_fifo_din;
    logic                 rx_fifo_wr;

    modport master (
        output cr_en, req_valid, req_addr, req_rw, req_len, wr_valid, wr_data,
        output tx_fifo_full, rx_fifo_wr,
        input  req_ready, wr_ready, done, err, busy, grant_id, tx_fifo_wr, tx_fifo_din
    );

    modport slave (
        input  cr_en, req_valid, req_addr, req_rw, req_len, wr_valid, wr_data,
        input  tx_fifo_full, rx_fifo_wr,
        output req_ready, wr_ready, done, err, busy, grant_id, tx_fifo_wr, tx_fifo_din
    );
endinterface

// File: rtl/i2c_dyna_cmd_arb.sv
// Round-robin command arbiter that serialises whole client transactions into
// 10-bit dynamic-mode TX FIFO words and holds ownership until read bytes arrive.
module i2c_dyna_cmd_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    i2c_dyna_cmd_arb_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_COUNT,
        S_WAIT_RX,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic [6:0]     addr_q, addr_d;
    logic           rw_q, rw_d;
    logic [7:0]     len_q, len_d;
    logic [7:0]     cnt_q, cnt_d;

    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [6:0]     win_addr;
    logic           win_rw;
    logic [7:0]     win_len;

    logic           own_wvalid;
    logic [7:0]     own_wdata;

    logic           accept;
    logic           own_wr_rdy;
    logic           in_done;
    logic           fifo_wr;
    logic [9:0]     fifo_din;

    // Round robin: lowest requester above last_q wins, otherwise wrap to the lowest at or below it.
    always_comb begin
        logic           found_hi;
        logic           found_lo;
        logic [IDW-1:0] idx_hi;
        logic [IDW-1:0] idx_lo;
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                if (i > int'(last_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = IDW'(i);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = IDW'(i);
                end
            end
        end
        win_found = found_hi | found_lo;
        win_idx   = found_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        win_addr   = '0;
        win_rw     = 1'b0;
        win_len    = '0;
        own_wvalid = 1'b0;
        own_wdata  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                win_addr = bus.req_addr[7*i +: 7];
                win_rw   = bus.req_rw[i];
                win_len  = bus.req_len[8*i +: 8];
            end
            if (grant_q == IDW'(i)) begin
                own_wvalid = bus.wr_valid[i];
                own_wdata  = bus.wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        own_wr_rdy = 1'b0;
        in_done    = 1'b0;
        fifo_wr    = 1'b0;
        fifo_din   = '0;

        case (state_q)
            S_IDLE: begin
                // Gating on rst keeps req_ready/busy at their reset values while reset is held.
                if (bus.cr_en && win_found && !rst) begin
                    accept  = 1'b1;
                    grant_d = win_idx;
                    addr_d  = win_addr;
                    rw_d    = win_rw;
                    len_d   = win_len;
                    cnt_d   = win_len;
                    state_d = (win_len == 8'd0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                if (!bus.tx_fifo_full) begin
                    fifo_wr  = 1'b1;
                    fifo_din = {1'b0, 1'b1, addr_q, rw_q};
                    state_d  = rw_q ? S_COUNT : S_DATA;
                end
            end
            S_DATA: begin
                own_wr_rdy = !bus.tx_fifo_full;
                if (!bus.tx_fifo_full && own_wvalid && cnt_q != 8'd0) begin
                    fifo_wr  = 1'b1;
                    fifo_din = {(cnt_q == 8'd1), 1'b0, own_wdata};
                    cnt_d    = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_COUNT: begin
                if (!bus.tx_fifo_full) begin
                    fifo_wr  = 1'b1;
                    fifo_din = {1'b1, 1'b0, len_q};
                    cnt_d    = len_q;
                    state_d  = S_WAIT_RX;
                end
            end
            S_WAIT_RX: begin
                if (bus.rx_fifo_wr && cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                in_done = 1'b1;
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= IDW'(NREQ - 1);
            addr_q  <= '0;
            rw_q    <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.wr_ready  = '0;
        bus.done      = '0;
        bus.err       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (accept && win_idx == IDW'(i)) begin
                bus.req_ready[i] = 1'b1;
            end
            if (grant_q == IDW'(i)) begin
                bus.wr_ready[i] = own_wr_rdy;
                bus.done[i]     = in_done;
                bus.err[i]      = in_done && (len_q == 8'd0);
            end
        end
    end

    assign bus.busy        = accept || (state_q != S_IDLE);
    assign bus.grant_id    = grant_q;
    assign bus.tx_fifo_wr  = fifo_wr;
    assign bus.tx_fifo_din = fifo_din;

endmodule

// File: tb/tb_i2c_dyna_cmd_arb.sv
// Directed bench for i2c_dyna_cmd_arb: two clients, FIFO word capture and
// hand-computed expectations for each scenario.
module tb_i2c_dyna_cmd_arb;

    localparam int NREQ = 2;
    localparam int IDW  = 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    i2c_dyna_cmd_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    i2c_dyna_cmd_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0] wq[$];
    int         full_viol = 0;
    logic [7:0] wbytes[8];

    // Capture every FIFO write mid-cycle; inputs only change just after posedge.
    always @(negedge clk) begin
        if (bus.tx_fifo_wr) begin
            wq.push_back(bus.tx_fifo_din);
            if (bus.tx_fifo_full) full_viol++;
        end
    end

    task automatic idle_inputs();
        bus.cr_en        = 1'b1;
        bus.req_valid    = '0;
        bus.req_addr     = '0;
        bus.req_rw       = '0;
        bus.req_len      = '0;
        bus.wr_valid     = '0;
        bus.wr_data      = '0;
        bus.tx_fifo_full = 1'b0;
        bus.rx_fifo_wr   = 1'b0;
    endtask

    // Runs one transaction for client c and reports what was observed.
    task automatic drive_txn(input int c, input logic [6:0] a, input logic rw, input logic [7:0] len,
                             input int stall_at, input int stall_n, input bit drop_cr,
                             output int acc_cyc, output int done_cyc, output int last_rx,
                             output logic [1:0] done_v, output logic [1:0] err_v,
                             output int stall_bad, output int gid_bad, output bit ok);
        bit accepted = 0;
        bit cnt_seen = 0;
        int ptr = 0;
        int rxn = 0;
        int k = 0;
        acc_cyc = -1; done_cyc = -1; last_rx = -1; done_v = '0; err_v = '0;
        stall_bad = 0; gid_bad = 0; ok = 0;
        while (k < 200 && !ok) begin
            @(posedge clk); #1;
            bus.req_valid              = '0;
            bus.req_valid[c]           = !accepted;
            bus.req_addr[7*c +: 7]     = a;
            bus.req_rw[c]              = rw;
            bus.req_len[8*c +: 8]      = len;
            bus.wr_valid               = '0;
            bus.wr_valid[c]            = accepted && !rw && (ptr < int'(len));
            bus.wr_data[8*c +: 8]      = wbytes[ptr % 8];
            bus.tx_fifo_full           = (k >= stall_at) && (k < stall_at + stall_n);
            bus.rx_fifo_wr             = cnt_seen && (rxn < int'(len));
            bus.cr_en                  = !(drop_cr && accepted);
            @(negedge clk);
            if (!accepted && bus.req_ready[c]) begin
                accepted = 1;
                acc_cyc  = cyc;
            end
            if (bus.wr_valid[c] && bus.wr_ready[c]) ptr++;
            if (bus.tx_fifo_full && (bus.wr_ready != '0 || bus.tx_fifo_wr)) stall_bad++;
            if (bus.rx_fifo_wr) begin
                rxn++;
                last_rx = cyc;
            end
            if (cnt_seen && bus.grant_id != 3'(c)) gid_bad++;
            if (rw && bus.tx_fifo_wr && bus.tx_fifo_din[9]) cnt_seen = 1;
            if (bus.done[c]) begin
                ok       = 1;
                done_cyc = cyc;
                done_v   = bus.done;
                err_v    = bus.err;
            end
            k++;
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
        n_cmp++; if (bus.wr_ready !== 2'b00) begin n_bad++; $display("FAIL reset_wr_ready: got %b want 00", bus.wr_ready); end
        n_cmp++; if (bus.done !== 2'b00 || bus.err !== 2'b00) begin n_bad++; $display("FAIL reset_done_err: got %b/%b want 00/00", bus.done, bus.err); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.grant_id !== 3'd0) begin n_bad++; $display("FAIL reset_grant_id: got %0d want 0", bus.grant_id); end
        n_cmp++; if (bus.tx_fifo_wr !== 1'b0 || bus.tx_fifo_din !== 10'h000) begin n_bad++; $display("FAIL reset_fifo: got wr=%b din=%h want 0/000", bus.tx_fifo_wr, bus.tx_fifo_din); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] grants[4];
        int         gcyc[4];
        int         ng = 0;
        int         k = 0;
        logic [9:0] exp_w[8] = '{10'h120, 10'h2AA, 10'h122, 10'h2BB, 10'h120, 10'h2AA, 10'h122, 10'h2BB};
        wq.delete();
        @(posedge clk); #1;
        bus.req_addr  = {7'h11, 7'h10};
        bus.req_rw    = 2'b00;
        bus.req_len   = {8'd1, 8'd1};
        bus.wr_data   = {8'hBB, 8'hAA};
        bus.wr_valid  = 2'b11;
        bus.req_valid = 2'b11;
        while (ng < 4 && k < 60) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                grants[ng] = bus.req_ready;
                gcyc[ng]   = cyc;
                ng++;
            end
            k++;
            if (ng == 4) begin
                @(posedge clk); #1;
                bus.req_valid = 2'b00;
            end
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.busy && k < 20);
        idle_inputs();
        n_cmp++; if (ng !== 4) begin n_bad++; $display("FAIL rr_grant_count: got %0d want 4", ng); end
        for (int i = 0; i < 4; i++) begin
            logic [1:0] e;
            e = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++; if (i >= ng || grants[i] !== e) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", i, grants[i], e); end
        end
        n_cmp++; if (ng < 2 || gcyc[1] - gcyc[0] !== 4) begin n_bad++; $display("FAIL rr_spacing: got %0d want 4", gcyc[1] - gcyc[0]); end
        n_cmp++; if (wq.size() !== 8) begin n_bad++; $display("FAIL rr_word_count: got %0d want 8", wq.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [9:0] g;
            g = (i < wq.size()) ? wq[i] : 10'h3FF;
            n_cmp++; if (g !== exp_w[i]) begin n_bad++; $display("FAIL rr_word%0d: got %h want %h", i, g, exp_w[i]); end
        end
    endtask

    task automatic test_single_write();
        int acc, dn, lrx, sb, gb;
        logic [1:0] dv, ev;
        bit ok;
        logic [9:0] exp_w[3] = '{10'h1A0, 10'h0A5, 10'h23C};
        wq.delete();
        wbytes[0] = 8'hA5; wbytes[1] = 8'h3C;
        drive_txn(0, 7'h50, 1'b0, 8'd2, 1000, 0, 1'b0, acc, dn, lrx, dv, ev, sb, gb, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wr_timeout: got done=%b want 1", ok); end
        n_cmp++; if (wq.size() !== 3) begin n_bad++; $display("FAIL wr_word_count: got %0d want 3", wq.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [9:0] g;
            g = (i < wq.size()) ? wq[i] : 10'h3FF;
            n_cmp++; if (g !== exp_w[i]) begin n_bad++; $display("FAIL wr_word%0d: got %h want %h", i, g, exp_w[i]); end
        end
        n_cmp++; if (dv !== 2'b01 || ev !== 2'b00) begin n_bad++; $display("FAIL wr_done_err: got %b/%b want 01/00", dv, ev); end
        n_cmp++; if (dn - acc !== 4) begin n_bad++; $display("FAIL wr_latency: got %0d want 4", dn - acc); end
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_read();
        int acc, dn, lrx, sb, gb;
        logic [1:0] dv, ev;
        bit ok;
        logic [9:0] exp_w[2] = '{10'h143, 10'h203};
        wq.delete();
        drive_txn(1, 7'h21, 1'b1, 8'd3, 1000, 0, 1'b0, acc, dn, lrx, dv, ev, sb, gb, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rd_timeout: got done=%b want 1", ok); end
        n_cmp++; if (wq.size() !== 2) begin n_bad++; $display("FAIL rd_word_count: got %0d want 2", wq.size()); end
        for (int i = 0; i < 2; i++) begin
            logic [9:0] g;
            g = (i < wq.size()) ? wq[i] : 10'h3FF;
            n_cmp++; if (g !== exp_w[i]) begin n_bad++; $display("FAIL rd_word%0d: got %h want %h", i, g, exp_w[i]); end
        end
        n_cmp++; if (dv !== 2'b10) begin n_bad++; $display("FAIL rd_done: got %b want 10", dv); end
        n_cmp++; if (dn !== lrx + 1) begin n_bad++; $display("FAIL rd_done_timing: got cycle %0d want %0d", dn, lrx + 1); end
        n_cmp++; if (gb !== 0) begin n_bad++; $display("FAIL rd_grant_id: got %0d bad cycles want 0", gb); end
    endtask

    task automatic test_backpressure();
        int acc, dn, lrx, sb, gb;
        logic [1:0] dv, ev;
        bit ok;
        logic [9:0] exp_w[4] = '{10'h160, 10'h011, 10'h022, 10'h233};
        wq.delete();
        wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33;
        drive_txn(0, 7'h30, 1'b0, 8'd3, 3, 5, 1'b0, acc, dn, lrx, dv, ev, sb, gb, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_timeout: got done=%b want 1", ok); end
        for (int i = 0; i < 4; i++) begin
            logic [9:0] g;
            g = (i < wq.size()) ? wq[i] : 10'h3FF;
            n_cmp++; if (g !== exp_w[i]) begin n_bad++; $display("FAIL bp_word%0d: got %h want %h", i, g, exp_w[i]); end
        end
        n_cmp++; if (sb !== 0) begin n_bad++; $display("FAIL bp_stall_activity: got %0d cycles want 0", sb); end
        n_cmp++; if (full_viol !== 0) begin n_bad++; $display("FAIL bp_write_while_full: got %0d want 0", full_viol); end
        n_cmp++; if (dn - acc !== 10) begin n_bad++; $display("FAIL bp_latency: got %0d want 10", dn - acc); end
    endtask

    task automatic test_len_zero();
        int acc, dn, lrx, sb, gb;
        logic [1:0] dv, ev;
        bit ok;
        wq.delete();
        drive_txn(1, 7'h05, 1'b0, 8'd0, 1000, 0, 1'b0, acc, dn, lrx, dv, ev, sb, gb, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL len0_timeout: got done=%b want 1", ok); end
        n_cmp++; if (dv !== 2'b10 || ev !== 2'b10) begin n_bad++; $display("FAIL len0_done_err: got %b/%b want 10/10", dv, ev); end
        n_cmp++; if (dn - acc !== 1) begin n_bad++; $display("FAIL len0_latency: got %0d want 1", dn - acc); end
        n_cmp++; if (wq.size() !== 0) begin n_bad++; $display("FAIL len0_fifo_writes: got %0d want 0", wq.size()); end
    endtask

    task automatic test_cr_en_block();
        @(posedge clk); #1;
        bus.cr_en         = 1'b0;
        bus.req_addr[6:0] = 7'h12;
        bus.req_len[7:0]  = 8'd1;
        bus.req_valid     = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.req_ready !== 2'b00 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL cr_en_block%0d: got ready=%b busy=%b want 00/0", i, bus.req_ready, bus.busy); end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_cr_drop();
        int acc, dn, lrx, sb, gb;
        logic [1:0] dv, ev;
        bit ok;
        logic [9:0] exp_w[3] = '{10'h1FE, 10'h05A, 10'h26B};
        wq.delete();
        wbytes[0] = 8'h5A; wbytes[1] = 8'h6B;
        drive_txn(0, 7'h7F, 1'b0, 8'd2, 1000, 0, 1'b1, acc, dn, lrx, dv, ev, sb, gb, ok);
        n_cmp++; if (ok !== 1'b1 || dv !== 2'b01) begin n_bad++; $display("FAIL crdrop_done: got ok=%b done=%b want 1/01", ok, dv); end
        for (int i = 0; i < 3; i++) begin
            logic [9:0] g;
            g = (i < wq.size()) ? wq[i] : 10'h3FF;
            n_cmp++; if (g !== exp_w[i]) begin n_bad++; $display("FAIL crdrop_word%0d: got %h want %h", i, g, exp_w[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int  k = 0;
        bit  seen = 0;
        @(posedge clk); #1;
        bus.req_addr[13:7] = 7'h44;
        bus.req_rw         = 2'b10;
        bus.req_len[15:8]  = 8'd2;
        bus.req_valid      = 2'b10;
        while (!seen && k < 30) begin
            @(negedge clk);
            if (bus.req_ready[1]) begin
                @(posedge clk); #1;
                bus.req_valid = 2'b00;
            end else begin
                if (bus.tx_fifo_wr && bus.tx_fifo_din[9]) seen = 1;
                k++;
            end
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rstmid_count_word: got %b want 1", seen); end
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1 || bus.grant_id !== 3'd1) begin n_bad++; $display("FAIL rstmid_pre: got busy=%b gid=%0d want 1/1", bus.busy, bus.grant_id); end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.grant_id !== 3'd0) begin n_bad++; $display("FAIL rstmid_async: got busy=%b gid=%0d want 0/0", bus.busy, bus.grant_id); end
        n_cmp++; if (bus.done !== 2'b00 || bus.err !== 2'b00 || bus.req_ready !== 2'b00 || bus.wr_ready !== 2'b00) begin n_bad++; $display("FAIL rstmid_handshake: got done=%b err=%b rr=%b wr=%b want 0s", bus.done, bus.err, bus.req_ready, bus.wr_ready); end
        n_cmp++; if (bus.tx_fifo_wr !== 1'b0 || bus.tx_fifo_din !== 10'h000) begin n_bad++; $display("FAIL rstmid_fifo: got wr=%b din=%h want 0/000", bus.tx_fifo_wr, bus.tx_fifo_din); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        bus.req_addr  = {7'h22, 7'h11};
        bus.req_len   = {8'd1, 8'd1};
        bus.req_valid = 2'b11;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL rstmid_first_grant: got %b want 01", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if (bus.grant_id !== 3'd0) begin n_bad++; $display("FAIL rstmid_grant_id: got %0d want 0", bus.grant_id); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 8; i++) wbytes[i] = 8'h00;
        test_reset();
        test_round_robin();
        test_single_write();
        test_read();
        test_backpressure();
        test_len_zero();
        test_cr_en_block();
        test_cr_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
